// File: rtl/fill_pkg.sv
// Shared types, constants and a reference replication function for the pattern fill engine.
package fill_pkg;

  localparam int unsigned REP             = 4;
  localparam int unsigned FILL_MAX_ELEM_W = 8;
  localparam int unsigned FILL_DATA_W     = 32;

  // Element width minus one: 0 means a 1-bit element, 7 an 8-bit element.
  typedef logic [2:0] width_code_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Loop-based replication: REP copies of the low (code+1) pattern bits, zero-extended.
  function automatic logic [FILL_DATA_W-1:0] replicate(input logic [FILL_MAX_ELEM_W-1:0] pattern,
                                                       input width_code_t code);
    logic [FILL_DATA_W-1:0] word;
    int w;
    word = '0;
    w    = int'(code) + 1;
    for (int r = 0; r < int'(REP); r++) begin
      for (int b = 0; b < int'(FILL_MAX_ELEM_W); b++) begin
        if (b < w) begin
          word[r * w + b] = pattern[b];
        end
      end
    end
    return word;
  endfunction

endpackage

// File: rtl/pattern_dup.sv
// Combinational replicator: pattern and width code to a zero-extended word of REP copies.
module pattern_dup
  import fill_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_ELEM_W = 8
) (
  input  logic [MAX_ELEM_W-1:0] pattern_i,
  input  width_code_t           width_code_i,
  output logic [DATA_W-1:0]     word_o
);

  // Pick the replication for the selected element width; pattern bits above it are dropped.
  always_comb begin
    word_o = '0;
    unique case (width_code_i)
      3'd0: word_o = DATA_W'({REP{pattern_i[0]}});
      3'd1: word_o = DATA_W'({REP{pattern_i[1:0]}});
      3'd2: word_o = DATA_W'({REP{pattern_i[2:0]}});
      3'd3: word_o = DATA_W'({REP{pattern_i[3:0]}});
      3'd4: word_o = DATA_W'({REP{pattern_i[4:0]}});
      3'd5: word_o = DATA_W'({REP{pattern_i[5:0]}});
      3'd6: word_o = DATA_W'({REP{pattern_i[6:0]}});
      3'd7: word_o = DATA_W'({REP{pattern_i[7:0]}});
    endcase
  end

endmodule

// File: rtl/pattern_fill_engine.sv
// Streams a replicated pattern word for cmd_count beats per accepted fill command.
module pattern_fill_engine
  import fill_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_ELEM_W = 8,
  parameter int unsigned COUNT_W    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [MAX_ELEM_W-1:0] cmd_pattern,
  input  logic [2:0]            cmd_width,
  input  logic [COUNT_W-1:0]    cmd_count,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  state_e              state_q, state_d;
  logic [COUNT_W-1:0]  remaining_q, remaining_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   dup_word;

  pattern_dup #(
    .DATA_W    (DATA_W),
    .MAX_ELEM_W(MAX_ELEM_W)
  ) u_pattern_dup (
    .pattern_i   (cmd_pattern),
    .width_code_i(cmd_width),
    .word_o      (dup_word)
  );

  // Outputs decoded from registered state; cmd_ready is forced low while reset is held.
  always_comb begin
    cmd_ready = (state_q == IDLE) && !reset;
    out_valid = valid_q;
    out_data  = data_q;
    out_last  = valid_q && (remaining_q == COUNT_W'(1));
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
  end

  // Next-state: latch the command in IDLE, count handshakes in RUN, pulse done once.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    valid_d     = valid_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          data_d      = dup_word;
          remaining_d = cmd_count;
          if (cmd_count == '0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            valid_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (out_ready) begin
          remaining_d = remaining_q - COUNT_W'(1);
          if (remaining_q == COUNT_W'(1)) begin
            valid_d = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any burst in progress without a done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
    end
  end

endmodule

// File: tb/tb_pattern_fill_engine.sv
// Directed bench for pattern_fill_engine with hand-computed expected words.
module tb_pattern_fill_engine;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_pattern;
  logic [2:0]  cmd_width;
  logic [15:0] cmd_count;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  int n_pass  = 0;
  int n_total = 0;

  pattern_fill_engine #(
    .DATA_W    (32),
    .MAX_ELEM_W(8),
    .COUNT_W   (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_pattern(cmd_pattern),
    .cmd_width  (cmd_width),
    .cmd_count  (cmd_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance one clock and return at the following falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Issue one command and follow it to completion. With stall set, out_ready is low in
  // burst cycles 2 and 3. Checks data, last, valid continuity, beat count and done timing.
  task automatic run_cmd(input string tag, input logic [7:0] pat, input logic [2:0] wc,
                         input int cnt, input logic [31:0] exp, input bit stall);
    int beats;
    int done_cyc;
    int stalls;
    chk({tag, ".cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid   = 1'b1;
    cmd_pattern = pat;
    cmd_width   = wc;
    cmd_count   = 16'(cnt);
    out_ready   = 1'b1;
    step();
    cmd_valid = 1'b0;
    beats     = 0;
    done_cyc  = -1;
    stalls    = (stall && cnt >= 3) ? 2 : 0;
    for (int cyc = 1; cyc <= cnt + 20; cyc++) begin
      out_ready = !(stall && (cyc == 2 || cyc == 3));
      if (done) begin
        done_cyc = cyc;
        break;
      end
      chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, beats < cnt});
      if (out_valid) begin
        chk({tag, ".data"}, out_data, exp);
        chk({tag, ".last"}, {31'd0, out_last}, {31'd0, beats == cnt - 1});
        if (out_ready) beats++;
      end
      step();
    end
    out_ready = 1'b1;
    chk({tag, ".beats"}, 32'(beats), 32'(cnt));
    chk({tag, ".done_cycle"}, 32'(done_cyc), 32'(cnt + stalls + 1));
    chk({tag, ".done_valid"}, {31'd0, out_valid}, 32'd0);
    step();
    chk({tag, ".done_width"}, {31'd0, done}, 32'd0);
    chk({tag, ".ready_back"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, ".idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_pattern = '0;
    cmd_width   = '0;
    cmd_count   = '0;
    out_ready   = 1'b1;
    step();
    chk("rst.cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.out_data", out_data, 32'd0);
    chk("rst.out_last", {31'd0, out_last}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    step();
    chk("idle.cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Basic 1-bit element, three beats at full throughput.
    run_cmd("w0", 8'h01, 3'd0, 3, 32'h0000000F, 1'b0);

    // Width sweep with pattern 1.
    run_cmd("w2", 8'h01, 3'd2, 1, 32'h00000249, 1'b0);
    run_cmd("w4", 8'h01, 3'd4, 1, 32'h00008421, 1'b0);
    run_cmd("w6", 8'h01, 3'd6, 1, 32'h00204081, 1'b0);
    run_cmd("w7", 8'h01, 3'd7, 1, 32'h01010101, 1'b0);

    // Upper pattern bits above the element width are ignored.
    run_cmd("w3", 8'hF3, 3'd3, 2, 32'h00003333, 1'b0);
    run_cmd("w1", 8'hFE, 3'd1, 2, 32'h000000AA, 1'b0);

    // Backpressure mid-burst holds data and last.
    run_cmd("stall", 8'h2D, 3'd5, 5, 32'h00B6DB6D, 1'b1);

    // Zero-length command: accepted, no beats, done one cycle later.
    run_cmd("zero", 8'hFF, 3'd7, 0, 32'h00000000, 1'b0);

    // Reset in the middle of a ten-beat burst.
    chk("abort.cmd_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid   = 1'b1;
    cmd_pattern = 8'hA5;
    cmd_width   = 3'd7;
    cmd_count   = 16'd10;
    out_ready   = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("abort.beat1", out_data, 32'hA5A5A5A5);
    step();
    chk("abort.beat2_valid", {31'd0, out_valid}, 32'd1);
    step();
    chk("abort.busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort.valid_async", {31'd0, out_valid}, 32'd0);
    chk("abort.busy_async", {31'd0, busy}, 32'd0);
    chk("abort.done_async", {31'd0, done}, 32'd0);
    chk("abort.ready_in_reset", {31'd0, cmd_ready}, 32'd0);
    step();
    chk("abort.no_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    step();
    chk("abort.no_done_after", {31'd0, done}, 32'd0);
    run_cmd("post", 8'h5C, 3'd2, 4, 32'h00000924, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
